serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. Adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first.
- The datapath is a single full-adder cell built from two half-adder cells (XOR for sum, AND for carry) and an OR of the two carries.
- The block provides the sequencing: operand shift registers, carry flip-flop, bit counter, FSM and start/done handshake.
- It sits beside the combinational adders as an area-minimal alternative to a WIDTH-bit ripple adder.

Parameters:
- WIDTH, 8, operand and result width in bits; legal values 1 to 32.

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      asynchronous active-low reset
- start  input   1      request; sampled only in IDLE
- a      input   WIDTH  operand A; captured on the accepted start edge
- b      input   WIDTH  operand B; captured on the accepted start edge
- cin    input   1      carry-in; captured on the accepted start edge
- busy   output  1      high while in RUN
- done   output  1      one-cycle completion pulse; high while in DONE
- sum    output  WIDTH  registered result; held until the next completion
- cout   output  1      registered final carry; held with sum

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE. It also clears the operand shift registers, result shift register, carry flip-flop, counter, sum, cout, busy and done to 0.
- Reset mid-RUN aborts the operation. No done pulse is produced and sum/cout read 0.
- States: IDLE, RUN, DONE. State encoding is free.
- IDLE:
  - start=1 at edge E0 loads a, b and cin, clears the counter, and goes to RUN.
  - start=0 stays in IDLE.
- RUN, at each edge (one bit per edge):
  - Half-adder 1: p = a_sh[0] ^ b_sh[0], g1 = a_sh[0] & b_sh[0].
  - Half-adder 2: s = p ^ c, g2 = p & c.
  - New carry c = g1 | g2.
  - s shifts into the MSB of the result shift register; a_sh and b_sh shift right.
  - Counter increments.
  - On the edge where counter == WIDTH-1 (edge E_WIDTH): go to DONE, and copy the completed result shift register and the new carry into sum and cout at that same edge.
- DONE:
  - Lasts exactly one cycle, then IDLE.
  - start is ignored in DONE.
- Latency: start accepted at E0, sum/cout valid and done=1 after edge E_WIDTH. This is WIDTH cycles after acceptance. The next start can be accepted at edge E_WIDTH+2 (first IDLE cycle). Throughput is one addition per WIDTH+2 cycles.
- start while busy or done is ignored. It is neither queued nor re-captured, and a/b/cin changes during RUN have no effect.
- sum/cout do not change during RUN; they hold the previous result (0 after reset).
- Result equals (a + b + cin) mod 2^WIDTH, with cout = bit WIDTH of the full sum.
- WIDTH=1: RUN lasts a single edge. The counter is at least 1 bit wide, so there is no zero-width vector.
- busy and done are registered decodes of state; they are never both high.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, cin=0, one-cycle start -> busy high for 8 cycles, then done pulse for 1 cycle with sum=0x7F, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start held high continuously with changing a/b -> one operation per 10 cycles; each result matches operands present on its IDLE start edge; inputs changed in RUN are ignored.
- Pulse rst_n low in the 4th RUN cycle -> busy=0, done never pulses, sum=0x00, cout=0. The next start completes correctly.
- Back-to-back: result 0x7F held on sum through the entire next RUN; it updates only at that operation's done.
- Random regression, 1000 vectors, WIDTH=8 and WIDTH=1 -> {cout,sum} equals a+b+cin and done arrives exactly WIDTH cycles after the accepted start.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds a + b + cin one bit per clock, LSB first,
// through a single full-adder cell built from two half adders.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter is kept at least one bit wide so WIDTH=1 has no zero-width vector.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             p, g1, s, g2, carry_next;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    p          = a_sh[0] ^ b_sh[0];
    g1         = a_sh[0] & b_sh[0];
    s          = p ^ carry;
    g2         = p & carry;
    carry_next = g1 | g2;
    res_next   = res_sh >> 1;
    res_next[WIDTH-1] = s;
  end

  // sum/cout are only written on the final RUN edge, so they hold through the next RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          carry  <= carry_next;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= res_next;
            cout  <= carry_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances checked
// against an arithmetic model of (a + b + cin) with a WIDTH+2 cycle operation slot.
module tb_serial_add_ctrl;

  typedef struct packed {
    logic [32:0] res;
    longint      due;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;
  int     blk8     = 0;
  int     blk1     = 0;
  logic [32:0] hold8 = '0;
  logic [32:0] hold1 = '0;
  exp_t q8[$];
  exp_t q1[$];

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: an accepted start occupies the lane for WIDTH+1 further
  // edges; done is due exactly WIDTH edges after acceptance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk8 = 0;
      blk1 = 0;
      q8.delete();
      q1.delete();
    end else begin
      exp_t e;
      cyc++;
      if (blk8 > 0) blk8--;
      else if (start8) begin
        e.res = 33'(a8) + 33'(b8) + 33'(cin8);
        e.due = cyc + 8;
        q8.push_back(e);
        blk8 = 9;
      end
      if (blk1 > 0) blk1--;
      else if (start1) begin
        e.res = 33'(a1) + 33'(b1) + 33'(cin1);
        e.due = cyc + 1;
        q1.push_back(e);
        blk1 = 2;
      end
    end
  end

  // Monitor for the WIDTH=8 lane.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold8 = '0;
      checkOutput("rst8_outputs", {busy8, done8, cout8, sum8}, 64'd0);
    end else begin
      checkOutput("busy8", busy8, blk8 >= 2);
      checkOutput("done8", done8, blk8 == 1);
      if (done8) begin
        checkOutput("sb8_has_entry", q8.size() != 0, 1'b1);
        if (q8.size() != 0) begin
          e = q8.pop_front();
          checkOutput("result8", {cout8, sum8}, e.res[8:0]);
          checkOutput("latency8", cyc, e.due);
          hold8 = {24'd0, e.res[8:0]};
        end
      end else begin
        checkOutput("hold8", {cout8, sum8}, hold8[8:0]);
      end
    end
  end

  // Monitor for the WIDTH=1 lane.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold1 = '0;
      checkOutput("rst1_outputs", {busy1, done1, cout1, sum1}, 64'd0);
    end else begin
      checkOutput("busy1", busy1, blk1 >= 2);
      checkOutput("done1", done1, blk1 == 1);
      if (done1) begin
        checkOutput("sb1_has_entry", q1.size() != 0, 1'b1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          checkOutput("result1", {cout1, sum1}, e.res[1:0]);
          checkOutput("latency1", cyc, e.due);
          hold1 = {31'd0, e.res[1:0]};
        end
      end else begin
        checkOutput("hold1", {cout1, sum1}, hold1[1:0]);
      end
    end
  end

  task automatic waitIdle(input int lane);
    int n = 0;
    while (((lane == 8) ? (blk8 != 0 || q8.size() != 0) : (blk1 != 0 || q1.size() != 0)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("idle_timeout", n, 0);
  endtask

  // One-cycle start pulse once the lane is idle; accepted at the following edge.
  task automatic applyStimulus(input int lane, input logic [7:0] a, input logic [7:0] b, input logic c);
    waitIdle(lane);
    @(negedge clk);
    #1;
    if (lane == 8) begin
      a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    end else begin
      a1 = a[0:0]; b1 = b[0:0]; cin1 = c; start1 = 1'b1;
    end
    @(negedge clk);
    #1;
    start8 = 1'b0;
    start1 = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Directed: back-to-back operations, result held through the next RUN.
    applyStimulus(8, 8'h35, 8'h4A, 1'b0);
    applyStimulus(8, 8'hFF, 8'h01, 1'b0);
    applyStimulus(8, 8'hFF, 8'hFF, 1'b1);
    applyStimulus(8, 8'h35, 8'h4A, 1'b0);
    applyStimulus(8, 8'h00, 8'h00, 1'b0);

    // start held high with operands changing every cycle.
    waitIdle(8);
    @(negedge clk);
    #1 start8 = 1'b1;
    repeat (40) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      @(negedge clk);
      #1;
    end
    start8 = 1'b0;

    // Reset pulse during the 4th RUN cycle aborts the operation.
    applyStimulus(8, 8'hA5, 8'h5A, 1'b1);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(8, 8'h12, 8'h34, 1'b1);

    // WIDTH=1 corners.
    applyStimulus(1, 8'h1, 8'h1, 1'b1);
    applyStimulus(1, 8'h0, 8'h1, 1'b0);
    applyStimulus(1, 8'h0, 8'h0, 1'b0);

    // Random regression on both lanes with random idle gaps.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          applyStimulus(8, 8'($urandom), 8'($urandom), 1'($urandom));
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin
        for (int j = 0; j < 1000; j++) begin
          applyStimulus(1, 8'($urandom), 8'($urandom), 1'($urandom));
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    join

    waitIdle(8);
    waitIdle(1);
    repeat (2) @(negedge clk);
    checkOutput("drain8", q8.size(), 0);
    checkOutput("drain1", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
